// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 Set-2 scan-code path: protocol bytes, decoder
// states and the modifier bitmap layout.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_ERR       = 8'hFE;
  localparam logic [7:0] PS2_ECHO      = 8'hEE;
  localparam logic [7:0] PS2_OVR0      = 8'h00;
  localparam logic [7:0] PS2_OVR1      = 8'hFF;

  // PrintScreen wraps itself in fake E0-prefixed shift codes
  localparam logic [7:0] PS2_FAKE_LSH  = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSH  = 8'h59;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PS2_PAUSE_LAST = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } ps2_state_e;

  localparam logic [2:0] MOD_LSHIFT = 3'd0;
  localparam logic [2:0] MOD_RSHIFT = 3'd1;
  localparam logic [2:0] MOD_LCTRL  = 3'd2;
  localparam logic [2:0] MOD_RCTRL  = 3'd3;
  localparam logic [2:0] MOD_LALT   = 3'd4;
  localparam logic [2:0] MOD_RALT   = 3'd5;
  localparam logic [2:0] MOD_LGUI   = 3'd6;
  localparam logic [2:0] MOD_RGUI   = 3'd7;

  // Returns {hit, bit index} for a decoded {ext, code} pair
  function automatic logic [3:0] mod_lookup(input logic ext, input logic [7:0] code);
    logic [3:0] r;
    r = 4'b0000;
    case ({ext, code})
      9'h012:  r = {1'b1, MOD_LSHIFT};
      9'h059:  r = {1'b1, MOD_RSHIFT};
      9'h014:  r = {1'b1, MOD_LCTRL};
      9'h114:  r = {1'b1, MOD_RCTRL};
      9'h011:  r = {1'b1, MOD_LALT};
      9'h111:  r = {1'b1, MOD_RALT};
      9'h11F:  r = {1'b1, MOD_LGUI};
      9'h127:  r = {1'b1, MOD_RGUI};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// RX FIFO read side plus the key-event output towards the register block.
interface ps2_scancode_decoder_if;
  logic [7:0] kbd_rdata_i;
  logic       kbd_rvalid_i;
  logic       kbd_rdeq_o;
  logic [7:0] key_code_o;
  logic       key_ext_o;
  logic       key_break_o;
  logic       key_valid_o;
  logic       key_rdy_i;
  logic [7:0] mods_o;
  logic       drop_o;

  modport master (
    input  kbd_rdata_i, kbd_rvalid_i, key_rdy_i,
    output kbd_rdeq_o, key_code_o, key_ext_o, key_break_o, key_valid_o, mods_o, drop_o
  );

  modport slave (
    output kbd_rdata_i, kbd_rvalid_i, key_rdy_i,
    input  kbd_rdeq_o, key_code_o, key_ext_o, key_break_o, key_valid_o, mods_o, drop_o
  );
endinterface

// File: rtl/ps2_mod_tracker.sv
// Live modifier bitmap: set on make, clear on break, wiped on keyboard self-test.
module ps2_mod_tracker
  import ps2_pkg::*;
(
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       upd,
  input  logic       ext,
  input  logic       brk,
  input  logic [7:0] code,
  input  logic       clr,
  output logic [7:0] mods
);

  logic [3:0] hit_idx;
  assign hit_idx = mod_lookup(ext, code);

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      mods <= '0;
    end else if (clr) begin
      mods <= '0;
    end else if (upd && hit_idx[3]) begin
      mods[hit_idx[2:0]] <= ~brk;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Collapses Set-2 prefix sequences into single key events behind a one-deep
// valid/ready register, with a microsecond inter-byte timeout.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_US = 2000,
  parameter int TMR_W      = 11
) (
  input  logic clk6x,
  input  logic resetn,
  input  logic ck1us,
  ps2_scancode_decoder_if.master kbd
);

  ps2_state_e       state, cur, nxt;
  logic [2:0]       pcnt, nxt_pcnt;
  logic [TMR_W-1:0] tmr;
  logic             consume, timeout, stall;
  logic             emit, e_ext, e_brk, bad, bat;
  logic [7:0]       b, e_code, mods;

  assign stall          = kbd.key_valid_o & ~kbd.key_rdy_i;
  assign kbd.kbd_rdeq_o = kbd.kbd_rvalid_i & ~stall;
  assign consume        = kbd.kbd_rdeq_o;
  assign b              = kbd.kbd_rdata_i;
  assign timeout        = (state != ST_IDLE) && (tmr == TMR_W'(TIMEOUT_US));
  // A timed-out sequence is abandoned before the current byte is looked at
  assign cur            = timeout ? ST_IDLE : state;

  always_comb begin
    nxt      = cur;
    nxt_pcnt = pcnt;
    emit     = 1'b0;
    e_code   = b;
    e_ext    = 1'b0;
    e_brk    = 1'b0;
    bad      = 1'b0;
    bat      = 1'b0;
    if (consume) begin
      case (cur)
        ST_IDLE: begin
          if (b == PS2_PFX_EXT) nxt = ST_EXT;
          else if (b == PS2_PFX_BRK) nxt = ST_BRK;
          else if (b == PS2_PFX_PAUSE) begin
            nxt      = ST_PAUSE;
            nxt_pcnt = 3'd0;
          end else if (b == PS2_BAT_OK) bat = 1'b1;
          else if (b == PS2_ACK || b == PS2_ERR || b == PS2_ECHO) nxt = ST_IDLE;
          else if (b == PS2_OVR0 || b == PS2_OVR1) bad = 1'b1;
          else emit = 1'b1;
        end
        ST_EXT: begin
          nxt = ST_IDLE;
          if (b == PS2_PFX_BRK) nxt = ST_EXTBRK;
          else if (b == PS2_FAKE_LSH || b == PS2_FAKE_RSH) nxt = ST_IDLE;
          else if (b == PS2_PFX_EXT || b == PS2_PFX_PAUSE || b == PS2_OVR0 || b == PS2_OVR1)
            bad = 1'b1;
          else begin
            emit  = 1'b1;
            e_ext = 1'b1;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          nxt = ST_IDLE;
          if (b == PS2_PFX_EXT || b == PS2_PFX_PAUSE || b == PS2_PFX_BRK ||
              b == PS2_OVR0 || b == PS2_OVR1)
            bad = 1'b1;
          else if (cur == ST_EXTBRK && (b == PS2_FAKE_LSH || b == PS2_FAKE_RSH))
            nxt = ST_IDLE;
          else begin
            emit  = 1'b1;
            e_ext = (cur == ST_EXTBRK);
            e_brk = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (pcnt == PS2_PAUSE_LAST) begin
            nxt      = ST_IDLE;
            nxt_pcnt = 3'd0;
            emit     = 1'b1;
            e_code   = PS2_PAUSE_CODE;
            e_ext    = 1'b1;
          end else begin
            nxt_pcnt = pcnt + 3'd1;
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      pcnt            <= 3'd0;
      tmr             <= '0;
      kbd.drop_o      <= 1'b0;
      kbd.key_valid_o <= 1'b0;
      kbd.key_code_o  <= 8'h00;
      kbd.key_ext_o   <= 1'b0;
      kbd.key_break_o <= 1'b0;
    end else begin
      state      <= nxt;
      pcnt       <= nxt_pcnt;
      kbd.drop_o <= timeout | bad;
      if (consume || nxt == ST_IDLE) tmr <= '0;
      else tmr <= tmr + {{(TMR_W-1){1'b0}}, ck1us};
      if (emit) begin
        kbd.key_valid_o <= 1'b1;
        kbd.key_code_o  <= e_code;
        kbd.key_ext_o   <= e_ext;
        kbd.key_break_o <= e_brk;
      end else if (kbd.key_valid_o && kbd.key_rdy_i) begin
        kbd.key_valid_o <= 1'b0;
        kbd.key_code_o  <= 8'h00;
        kbd.key_ext_o   <= 1'b0;
        kbd.key_break_o <= 1'b0;
      end
    end
  end

  ps2_mod_tracker u_mods (
    .clk6x  (clk6x),
    .resetn (resetn),
    .upd    (emit),
    .ext    (e_ext),
    .brk    (e_brk),
    .code   (e_code),
    .clr    (bat),
    .mods   (mods)
  );

  assign kbd.mods_o = mods;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: byte FIFO model feeds the decoder, expected events go
// through a scoreboard queue and are matched on every accepted event.
module tb_ps2_scancode_decoder;

  logic clk6x = 1'b0;
  logic resetn = 1'b0;
  logic ck1us = 1'b0;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.TIMEOUT_US(2000), .TMR_W(11)) dut (
    .clk6x  (clk6x),
    .resetn (resetn),
    .ck1us  (ck1us),
    .kbd    (bus)
  );

  always #10 clk6x = ~clk6x;

  logic [7:0] tx_q[$];
  logic [9:0] sb[$];
  int checks = 0;
  int errors = 0;
  int drops  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_q.push_back(b);
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
    sb.push_back({code, ext, brk});
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk6x);
      if (tx_q.size() == 0 && !bus.key_valid_o) done = 1'b1;
    end
    if (!done) chk({tag, "_drain_timeout"}, 32'd0, 32'd1);
    repeat (2) @(negedge clk6x);
  endtask

  // RX FIFO model: pop on dequeue, present new head shortly after the edge
  always @(posedge clk6x) begin
    if (bus.kbd_rdeq_o && tx_q.size() > 0) void'(tx_q.pop_front());
    #1;
    bus.kbd_rvalid_i = (tx_q.size() != 0);
    bus.kbd_rdata_i  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  end

  always @(negedge clk6x) begin
    logic [9:0] exp_ev;
    if (bus.drop_o) drops++;
    if (resetn && bus.key_valid_o && bus.key_rdy_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {22'd0, bus.key_code_o, bus.key_ext_o, bus.key_break_o}, 32'h3FF);
      end else begin
        exp_ev = sb.pop_front();
        chk("event", {22'd0, bus.key_code_o, bus.key_ext_o, bus.key_break_o}, {22'd0, exp_ev});
      end
    end
  end

  initial begin
    int d0;
    bus.kbd_rvalid_i = 1'b0;
    bus.kbd_rdata_i  = 8'h00;
    bus.key_rdy_i    = 1'b1;

    repeat (3) @(posedge clk6x);
    @(negedge clk6x);
    chk("rst_valid", {31'd0, bus.key_valid_o}, 32'd0);
    chk("rst_mods", {24'd0, bus.mods_o}, 32'd0);
    chk("rst_drop", {31'd0, bus.drop_o}, 32'd0);
    chk("rst_code", {24'd0, bus.key_code_o}, 32'd0);
    @(posedge clk6x); #1 resetn = 1'b1;

    // plain make and break
    d0 = drops;
    expect_ev(8'h1C, 0, 0); expect_ev(8'h1C, 0, 1);
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("t1");
    chk("t1_nodrop", drops - d0, 0);

    // RCtrl make, extended break, PrintScreen fake shift filtered
    expect_ev(8'h14, 1, 0);
    send(8'hE0); send(8'h14);
    drain("t2a");
    chk("t2_mods_rctrl", {24'd0, bus.mods_o}, 32'h08);
    expect_ev(8'h14, 1, 1);
    send(8'hE0); send(8'hF0); send(8'h14);
    drain("t2b");
    chk("t2_mods_clear", {24'd0, bus.mods_o}, 32'h00);
    expect_ev(8'h7C, 1, 0);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    drain("t2c");
    chk("t2_mods_fake", {24'd0, bus.mods_o}, 32'h00);

    // LShift held through Pause
    expect_ev(8'h12, 0, 0);
    send(8'h12);
    drain("t3a");
    chk("t3_mods_lshift", {24'd0, bus.mods_o}, 32'h01);
    expect_ev(8'h77, 1, 0);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    drain("t3b");
    chk("t3_mods_pause", {24'd0, bus.mods_o}, 32'h01);

    // BAT clears modifiers, protocol bytes filtered, overrun dropped
    d0 = drops;
    send(8'hAA);
    drain("t6a");
    chk("t6_mods_bat", {24'd0, bus.mods_o}, 32'h00);
    send(8'hFA); send(8'hFE); send(8'hEE);
    drain("t6b");
    chk("t6_proto_nodrop", drops - d0, 0);
    send(8'h00);
    drain("t6c");
    chk("t6_ovr_drop", drops - d0, 1);

    // unexpected prefix after break prefix
    d0 = drops;
    send(8'hF0); send(8'hE0);
    drain("t7");
    chk("t7_bad_drop", drops - d0, 1);

    // backpressure
    bus.key_rdy_i = 1'b0;
    expect_ev(8'h16, 0, 0); expect_ev(8'h1E, 0, 0);
    send(8'h16); send(8'h1E);
    repeat (6) @(negedge clk6x);
    chk("t4_held_valid", {31'd0, bus.key_valid_o}, 32'd1);
    chk("t4_held_code", {24'd0, bus.key_code_o}, 32'h16);
    chk("t4_rdeq_low", {31'd0, bus.kbd_rdeq_o}, 32'd0);
    chk("t4_fifo_kept", tx_q.size(), 1);
    @(posedge clk6x); #1 bus.key_rdy_i = 1'b1;
    @(negedge clk6x);
    @(negedge clk6x);
    chk("t4_next_valid", {31'd0, bus.key_valid_o}, 32'd1);
    chk("t4_next_code", {24'd0, bus.key_code_o}, 32'h1E);
    drain("t4");

    // inter-byte timeout, one tick short and then exactly on the limit
    d0 = drops;
    send(8'hE0);
    drain("t5a");
    @(posedge clk6x); #1 ck1us = 1'b1;
    repeat (1999) @(posedge clk6x);
    #1 ck1us = 1'b0;
    repeat (4) @(negedge clk6x);
    chk("t5_no_early_drop", drops - d0, 0);
    @(posedge clk6x); #1 ck1us = 1'b1;
    @(posedge clk6x); #1 ck1us = 1'b0;
    repeat (4) @(negedge clk6x);
    chk("t5_timeout_drop", drops - d0, 1);
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    drain("t5b");

    // reset mid-sequence discards the prefix
    send(8'hE0);
    drain("t8a");
    @(posedge clk6x); #1 resetn = 1'b0;
    repeat (2) @(posedge clk6x);
    #1 resetn = 1'b1;
    expect_ev(8'h1C, 0, 0);
    send(8'h1C);
    drain("t8b");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS2 keyboard host's RX FIFO read interface.
- Pulls raw Set-2 scan-code bytes and collapses the prefix sequences (E0, F0, E0 F0, the 8-byte E1 Pause sequence) into single key events.
- Tracks a live modifier bitmap and filters out non-key protocol bytes (BAT, ACK, echo, overrun).
- Presents events through a one-deep valid/ready output register to the CPU-facing register block.

Parameters:
- TIMEOUT_US, 2000: maximum gap in µs between bytes of a multi-byte sequence before the partial sequence is discarded.
- TMR_W, 11: width of the µs timeout counter; must satisfy 2**TMR_W > TIMEOUT_US.

Ports:
- clk6x  in  1  48 MHz system clock
- resetn  in  1  synchronous reset, active-low
- ck1us  in  1  1 µs tick, one clk6x cycle wide
- kbd_rdata_i  in  8  RX FIFO head byte; don't-care when kbd_rvalid_i=0
- kbd_rvalid_i  in  1  RX FIFO not empty
- kbd_rdeq_o  out  1  dequeue RX FIFO head; asserted only when kbd_rvalid_i=1
- key_code_o  out  8  scan code of the event, prefixes stripped
- key_ext_o  out  1  event was E0-prefixed (or Pause)
- key_break_o  out  1  1 = key release, 0 = key press
- key_valid_o  out  1  event register full
- key_rdy_i  in  1  consumer accepts the event when key_valid_o & key_rdy_i
- mods_o  out  8  live modifier state: [0]LShift [1]RShift [2]LCtrl [3]RCtrl [4]LAlt [5]RAlt [6]LGUI [7]RGUI
- drop_o  out  1  one-cycle pulse when a byte or partial sequence is discarded (timeout, overrun 00/FF, unexpected byte)

Behaviour:
- Reset (resetn=0 at clk6x edge):
  - All outputs 0; state IDLE; timer 0.
  - Reset mid-sequence discards the partial sequence; no event is emitted.
- Input handshake:
  - kbd_rdeq_o = kbd_rvalid_i & !(key_valid_o & !key_rdy_i).
  - The decoder stalls while the event register is full and not being drained.
  - Exactly one byte is consumed per kbd_rdeq_o cycle.
- Latency: a completing byte dequeued in cycle N gives key_valid_o=1 and the mods_o update in cycle N+1.
- Event register:
  - Loaded only on a completing byte.
  - Holds its value while key_valid_o & !key_rdy_i.
  - Cleared the cycle after acceptance, unless reloaded in that same cycle.
- FSM (transitions happen only on consumed bytes b):
  - IDLE:
    - b=E0 → EXT
    - b=F0 → BRK
    - b=E1 → PAUSE, pcnt=0
    - b ∈ {AA, FA, FE, EE} → silently discarded, stay IDLE
    - b ∈ {00, FF} → drop_o, stay IDLE
    - otherwise emit {code=b, ext=0, brk=0}
  - EXT:
    - b=F0 → EXTBRK
    - b=12 or 59 (PrintScreen fake shift) → discard, IDLE
    - b ∈ {E0, E1, 00, FF} → drop_o, IDLE
    - otherwise emit {b, 1, 0}, IDLE
  - BRK:
    - b ∈ {E0, E1, F0, 00, FF} → drop_o, IDLE
    - otherwise emit {b, 0, 1}, IDLE
  - EXTBRK:
    - b=12 or 59 → discard, IDLE
    - b ∈ {E0, E1, F0, 00, FF} → drop_o, IDLE
    - otherwise emit {b, 1, 1}, IDLE
  - PAUSE:
    - Consume the 7 trailing bytes without checking them; pcnt increments on each.
    - On the 7th byte (pcnt=6) emit {77, 1, 0}, IDLE.
- Timeout:
  - Timer clears on every consumed byte and increments on ck1us while state ≠ IDLE.
  - When timer reaches TIMEOUT_US: state → IDLE, drop_o pulse, no event.
  - A byte consumed in the same cycle as the timeout is processed from IDLE.
- Modifiers:
  - On each emitted event whose {ext, code} matches, the bit is set on make and cleared on break.
  - Map: {0,12}→0, {0,59}→1, {0,14}→2, {1,14}→3, {0,11}→4, {1,11}→5, {1,1F}→6, {1,27}→7.
  - mods_o updates even if the event is later held by backpressure.
  - Receiving AA (BAT) clears mods_o to 0.
- Simultaneous acceptance and completing byte in the same cycle: the new event is loaded and key_valid_o stays 1, so no bubble occurs.

Decomposition:
- Shared package ps2_pkg:
  - byte constants PS2_PFX_EXT=E0, PS2_PFX_BRK=F0, PS2_PFX_PAUSE=E1, PS2_BAT_OK=AA, PS2_ACK=FA, PS2_ERR=FE, PS2_ECHO=EE, PS2_OVR0=00, PS2_OVR1=FF
  - FSM state encoding
  - modifier bit indices
- Optional sub-module ps2_mod_tracker: combinational {ext, code, brk} → modifier-bit update, plus the mods register.
- Everything else is inline.

Test Plan:
- Bytes 1C; F0 1C → events {1C,0,0} then {1C,0,1}; drop_o never pulses.
- E0 F0 14 with mods_o=08 beforehand → event {14,1,1}, mods_o=00; a following E0 12 E0 7C → only event {7C,1,0}.
- E1 14 77 E1 F0 14 F0 77 → exactly one event {77,1,0}, emitted on the 8th byte; mods_o unchanged.
- key_rdy_i held 0 with bytes 16, 1E queued → 16 is presented; kbd_rdeq_o=0 while held; raising key_rdy_i gives 1E on the next cycle with no lost byte.
- E0 followed by no byte for 2000 ck1us pulses → drop_o pulse; then 1C → event {1C,0,0}, not {1C,1,0}.
- 12 (mods_o=01), then AA → mods_o=00 with no event; bytes FA, FE, EE → no events; 00 → drop_o pulse.
